// File: rtl/fifo_serializer_if.sv
// Signal bundle between fifo_serializer, its rewindable packet FIFO and the bit-serial modulator.
interface fifo_serializer_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 6
);
  logic             start;
  logic             retry;
  logic             commit;
  logic [LEN_W-1:0] len;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_empty;
  logic             fifo_next;
  logic             fifo_firstbyte;
  logic             fifo_restart;
  logic             tx_bit;
  logic             tx_valid;
  logic             tx_ready;
  logic             busy;
  logic             done;
  logic             underrun;

  // tx_bit transfers on any cycle with tx_valid & tx_ready; once tx_valid rises it stays high
  // with tx_bit unchanged until that transfer. tx_ready while tx_valid is low means nothing.
  modport master (
    input  start, retry, commit, len, fifo_data, fifo_empty, tx_ready,
    output fifo_next, fifo_firstbyte, fifo_restart, tx_bit, tx_valid, busy, done, underrun
  );

  modport slave (
    output start, retry, commit, len, fifo_data, fifo_empty, tx_ready,
    input  fifo_next, fifo_firstbyte, fifo_restart, tx_bit, tx_valid, busy, done, underrun
  );
endinterface

// File: rtl/fifo_serializer.sv
// Packet serializer reading a rewindable FIFO: start/retry/commit control, MSB-first bit output.
// Define FIFO_SERIALIZER_CRC16_EN to append an inverted CRC-16 (0x1021, preset 0xFFFF) trailer.
module fifo_serializer #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  fifo_serializer_if.master        bus,
  output logic [3:0]               dbg_state_o
);
  localparam int BCW = $clog2((WIDTH > 16) ? WIDTH : 16);

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_REWIND_SETUP = 4'd1,
    S_REWIND_PULSE = 4'd2,
    S_COMMIT_SETUP = 4'd3,
    S_COMMIT_PULSE = 4'd4,
    S_LOAD         = 4'd5,
    S_SHIFT        = 4'd6,
    S_ADVANCE      = 4'd7,
    S_END          = 4'd8
`ifdef FIFO_SERIALIZER_CRC16_EN
    , S_CRC        = 4'd9
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             und_q, und_d;
`ifdef FIFO_SERIALIZER_CRC16_EN
  logic [15:0]      crc_q, crc_d;
`endif
  logic             next_q, next_d;
  logic             fb_q, fb_d;
  logic             rs_q, rs_d;
  logic             done_q, done_d;
  logic             under_q, under_d;
  logic             tx_valid, tx_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      und_q     <= 1'b0;
`ifdef FIFO_SERIALIZER_CRC16_EN
      crc_q     <= '0;
`endif
      next_q    <= 1'b0;
      fb_q      <= 1'b0;
      rs_q      <= 1'b0;
      done_q    <= 1'b0;
      under_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      und_q     <= und_d;
`ifdef FIFO_SERIALIZER_CRC16_EN
      crc_q     <= crc_d;
`endif
      next_q    <= next_d;
      fb_q      <= fb_d;
      rs_q      <= rs_d;
      done_q    <= done_d;
      under_q   <= under_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    und_d     = und_q;
`ifdef FIFO_SERIALIZER_CRC16_EN
    crc_d     = crc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.retry || bus.start) begin
          state_d = bus.retry ? S_REWIND_SETUP : S_LOAD;
          len_d   = bus.len;
          cnt_d   = '0;
          und_d   = 1'b0;
`ifdef FIFO_SERIALIZER_CRC16_EN
          crc_d   = 16'hFFFF;
`endif
        end
        // commit outranks start but not retry
        if (bus.commit && !bus.retry) begin
          state_d = S_COMMIT_SETUP;
          len_d   = len_q;
          cnt_d   = cnt_q;
          und_d   = und_q;
`ifdef FIFO_SERIALIZER_CRC16_EN
          crc_d   = crc_q;
`endif
        end
      end
      S_REWIND_SETUP: state_d = S_REWIND_PULSE;
      S_REWIND_PULSE: state_d = S_LOAD;
      S_COMMIT_SETUP: state_d = S_COMMIT_PULSE;
      S_COMMIT_PULSE: state_d = S_IDLE;
      S_LOAD: begin
        if (bus.fifo_empty) begin
          und_d = (len_q != '0) && (cnt_q < len_q);
`ifdef FIFO_SERIALIZER_CRC16_EN
          state_d   = S_CRC;
          bit_cnt_d = BCW'(15);
`else
          state_d   = S_END;
`endif
        end else begin
          shift_d   = bus.fifo_data;
          bit_cnt_d = BCW'(WIDTH - 1);
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bus.tx_ready) begin
`ifdef FIFO_SERIALIZER_CRC16_EN
          crc_d = {crc_q[14:0], 1'b0} ^ ({16{crc_q[15] ^ shift_q[WIDTH-1]}} & 16'h1021);
`endif
          shift_d = shift_q << 1;
          if (bit_cnt_q == '0) state_d = S_ADVANCE;
          else                 bit_cnt_d = bit_cnt_q - BCW'(1);
        end
      end
      S_ADVANCE: begin
        cnt_d = cnt_q + LEN_W'(1);
        if ((len_q != '0) && (cnt_d == len_q)) begin
`ifdef FIFO_SERIALIZER_CRC16_EN
          state_d   = S_CRC;
          bit_cnt_d = BCW'(15);
`else
          state_d   = S_END;
`endif
        end else begin
          state_d = S_LOAD;
        end
      end
`ifdef FIFO_SERIALIZER_CRC16_EN
      S_CRC: begin
        if (bus.tx_ready) begin
          crc_d = {crc_q[14:0], 1'b0};
          if (bit_cnt_q == '0) state_d = S_END;
          else                 bit_cnt_d = bit_cnt_q - BCW'(1);
        end
      end
`endif
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO strobes are decoded from the next state so they leave flops and never glitch
  always_comb begin
    next_d  = state_d inside {S_REWIND_PULSE, S_COMMIT_PULSE, S_ADVANCE};
    fb_d    = state_d inside {S_REWIND_SETUP, S_REWIND_PULSE, S_COMMIT_SETUP, S_COMMIT_PULSE};
    rs_d    = state_d inside {S_REWIND_SETUP, S_REWIND_PULSE};
    done_d  = (state_d == S_END);
    under_d = (state_d == S_END) && und_d;
    tx_valid = 1'b0;
    tx_bit   = 1'b0;
    case (state_q)
      S_SHIFT: begin
        tx_valid = 1'b1;
        tx_bit   = shift_q[WIDTH-1];
      end
`ifdef FIFO_SERIALIZER_CRC16_EN
      S_CRC: begin
        tx_valid = 1'b1;
        tx_bit   = ~crc_q[15];
      end
`endif
      default: ;
    endcase
  end

  assign bus.fifo_next      = next_q;
  assign bus.fifo_firstbyte = fb_q;
  assign bus.fifo_restart   = rs_q;
  assign bus.done           = done_q;
  assign bus.underrun       = under_q;
  assign bus.tx_valid       = tx_valid;
  assign bus.tx_bit         = tx_bit;
  assign bus.busy           = (state_q != S_IDLE);
  assign dbg_state_o        = state_q;
endmodule

// File: doc/fifo_serializer.md
FIFO_SERIALIZER -- requirements
Module: fifo_serializer

Interface
REQ-001 Parameter WIDTH, 8, FIFO byte width in bits.
REQ-002 Parameter LEN_W, 6, width of packet byte-length input.
REQ-003 One clock; reset is synchronous and active-high; ports named clk and reset.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 start  in  1  one-cycle request: transmit packet from FIFO current position.
REQ-007 retry  in  1  one-cycle request: rewind FIFO to last commit, then retransmit.
REQ-008 commit  in  1  one-cycle request: release transmitted bytes (packet acknowledged).
REQ-009 len  in  LEN_W  packet byte count, sampled on accepted start/retry; 0 = send until FIFO empty.
REQ-010 fifo_data  in  WIDTH  FIFO head byte.
REQ-011 fifo_empty  in  1  FIFO has no unread byte.
REQ-012 fifo_next  out  1  pulse that clocks the FIFO read side.
REQ-013 fifo_firstbyte  out  1  qualifies fifo_next as rewind/commit instead of advance.
REQ-014 fifo_restart  out  1  with fifo_firstbyte: 1 = rewind, 0 = commit.
REQ-015 tx_bit  out  1  serial data, MSB first.
REQ-016 tx_valid  out  1  tx_bit is valid.
REQ-017 tx_ready  in  1  modulator accepts tx_bit when tx_valid & tx_ready.
REQ-018 busy  out  1  state is not IDLE.
REQ-019 done  out  1  one-cycle pulse at packet end.
REQ-020 underrun  out  1  one-cycle pulse with done if FIFO emptied before len bytes sent.

Function
REQ-021 States SHALL be IDLE, REWIND_SETUP, REWIND_PULSE, COMMIT_SETUP, COMMIT_PULSE, LOAD, SHIFT, ADVANCE, [CRC], END.
REQ-022 In IDLE, request priority SHALL be retry > commit > start; requests outside IDLE are ignored.
REQ-023 Retry SHALL go REWIND_SETUP (firstbyte=1, restart=1, next=0) -> REWIND_PULSE (next=1) -> LOAD.
REQ-024 Commit SHALL go COMMIT_SETUP (firstbyte=1, restart=0, next=0) -> COMMIT_PULSE (next=1) -> IDLE; no done pulse.
REQ-025 fifo_firstbyte/fifo_restart SHALL change only while fifo_next=0 and stay stable through the pulse; both 0 outside REWIND/COMMIT states.
REQ-026 fifo_next SHALL be registered, high exactly one cycle per pulse.
REQ-027 LOAD: if fifo_empty -> END (underrun if len!=0 and count<len); else latch fifo_data into shift register, bit counter=WIDTH-1 -> SHIFT.
REQ-028 SHIFT: tx_valid=1, tx_bit=shift MSB; tx_bit held stable until tx_ready; on handshake shift left; after bit 0 -> ADVANCE.
REQ-029 ADVANCE: fifo_next=1 (firstbyte=0), byte count+1; if len!=0 and count reaches len -> END (or CRC), else LOAD next cycle.
REQ-030 END: done=1 one cycle -> IDLE; fifo pointers untouched until commit or retry.
REQ-031 Byte counter SHALL be LEN_W bits, cleared on accepted start/retry.
REQ-032 tx_ready with tx_valid=0 SHALL have no effect.

Reset
REQ-033 Reset SHALL force IDLE next edge; shift register, counters, all outputs 0.
REQ-034 Reset mid-packet SHALL emit no fifo_next pulse; an in-flight pulse is truncated to 0.

Configuration
REQ-035 Macro FIFO_SERIALIZER_CRC16_EN defined: after last payload byte, state CRC sends 16 bits MSB first via same handshake, ones-complement of CRC-16 (poly 0x1021, preset 0xFFFF) over all sent payload bits; preset on every start/retry; then END.
REQ-036 Macro undefined: no CRC state or logic; ADVANCE/LOAD end-of-packet goes directly to END.

Verification
REQ-037 FIFO holds 0xA5, start, len=1, tx_ready=1 -> bits 1,0,1,0,0,1,0,1, one fifo_next, done.
REQ-038 FIFO holds 2 bytes, len=3 -> 16 bits, done with underrun=1.
REQ-039 tx_ready low 5 cycles mid-byte -> tx_bit/tx_valid stable, no bit lost or duplicated.
REQ-040 Send 0x3C, then retry -> rewind pulse with firstbyte=1, restart=1, 0x3C resent; commit -> firstbyte=1, restart=0 pulse.
REQ-041 CRC16_EN, payload ASCII "123456789", len=9 -> 72 payload bits then 16'hD64E, done.
REQ-042 reset asserted in SHIFT -> next cycle busy=0, tx_valid=0, fifo_next=0; subsequent start works.
